// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
// Imported by alu_seq and alu_muldiv_seq.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_MUL  = 5'h02,
    OP_DIVU = 5'h03,
    OP_AND  = 5'h04,
    OP_OR   = 5'h05,
    OP_XOR  = 5'h06,
    OP_NOR  = 5'h07,
    OP_NOT  = 5'h08,
    OP_SLL  = 5'h09,
    OP_SRL  = 5'h0A,
    OP_SLT  = 5'h0B,
    OP_SLTU = 5'h0C,
    OP_INC  = 5'h0D,
    OP_DEC  = 5'h0E,
    OP_REMU = 5'h0F
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes that run through the iterative mul/div unit.
  function automatic logic is_iter(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider.
// One bit per cycle; done flags the final iteration edge.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run_q, run_d;
  logic             div_q, div_d;
  logic             div0_q, div0_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // mul: partial product; div: partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;
  // mul: multiplier (shifts right); div: dividend/quotient (shifts left)
  logic [WIDTH-1:0] sh_q, sh_d;
  // mul: multiplicand (shifts left); div: divisor
  logic [WIDTH-1:0] dv_q, dv_d;

  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;

  // Load on start, then advance one multiply or divide step per cycle.
  always_comb begin
    run_d  = run_q;
    div_d  = div_q;
    div0_d = div0_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    dv_d   = dv_q;
    rsh    = {acc_q, sh_q[WIDTH-1]};
    diff   = rsh - {1'b0, dv_q};
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      div_d  = (op != OP_MUL);
      div0_d = (op != OP_MUL) && (b == '0);
      acc_d  = '0;
      sh_d   = (op != OP_MUL) ? a : b;
      dv_d   = (op != OP_MUL) ? b : a;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        run_d = 1'b0;
      end
      if (div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rsh[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = acc_q + (sh_q[0] ? dv_q : '0);
        sh_d  = sh_q >> 1;
        dv_d  = dv_q << 1;
      end
    end
  end

  // Iteration state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      div0_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      dv_q   <= '0;
    end else begin
      run_q  <= run_d;
      div_q  <= div_d;
      div0_q <= div0_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      dv_q   <= dv_d;
    end
  end

  assign done      = run_q && (cnt_q == LAST);
  assign product   = acc_d;
  assign quotient  = sh_d;
  assign remainder = acc_d;
  assign div0      = div0_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish next cycle,
// mul/divu/remu iterate WIDTH cycles in alu_muldiv_seq.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             err
);

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_prod;
  logic [WIDTH-1:0] md_quot;
  logic [WIDTH-1:0] md_rem;
  logic             md_div0;

  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  logic             alu_err;
  logic [SHW-1:0]   amt;

  assign accept   = start && !busy_q && (state_q == ST_IDLE);
  assign md_start = accept && is_iter(opcode);
  assign amt      = b[SHW-1:0];

  alu_muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .op       (opcode),
    .a        (a),
    .b        (b),
    .done     (md_done),
    .product  (md_prod),
    .quotient (md_quot),
    .remainder(md_rem),
    .div0     (md_div0)
  );

  // Single-cycle datapath evaluated on the live inputs at accept.
  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    alu_err  = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_res  = a + b;
        alu_flag = (a == b);
      end
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_NOT: begin
        alu_res  = ~a;
        alu_flag = (a != b);
      end
      OP_SLL:  alu_res = a << amt;
      OP_SRL:  alu_res = a >> amt;
      OP_SLT: begin
        alu_flag = ($signed(a) < $signed(b));
        alu_res  = {{(WIDTH-1){1'b0}}, alu_flag};
      end
      OP_SLTU: begin
        alu_flag = (a < b);
        alu_res  = {{(WIDTH-1){1'b0}}, alu_flag};
      end
      OP_INC:  alu_res = a + WIDTH'(1);
      OP_DEC:  alu_res = a - WIDTH'(1);
      OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Control FSM next state and registered output values.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = opcode;
          busy_d = 1'b1;
          if (is_iter(opcode)) begin
            state_d = ST_CALC;
          end else begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = alu_res;
            flag_d   = alu_flag;
            err_d    = alu_err;
          end
        end
      end
      ST_CALC: begin
        if (md_done) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          flag_d  = 1'b0;
          err_d   = (op_q != OP_MUL) && md_div0;
          if (op_q == OP_MUL) begin
            result_d = md_prod;
          end else if (op_q == OP_DIVU) begin
            result_d = md_quot;
          end else begin
            result_d = md_rem;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;
  assign flag   = flag_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        flag;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(
    .WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .opcode(opcode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .valid (valid),
    .result(result),
    .flag  (flag),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [4:0] op,
                                 input logic [31:0] x,
                                 input logic [31:0] y,
                                 output logic [31:0] r,
                                 output logic f,
                                 output logic e,
                                 output int lat);
    r = 0; f = 0; e = 0; lat = 1;
    case (op)
      5'd0:  begin r = x + y; f = (x == y); end
      5'd1:  r = x - y;
      5'd2:  begin r = x * y; lat = 33; end
      5'd3:  begin
        lat = 33;
        if (y == 0) begin r = 32'hFFFF_FFFF; e = 1; end
        else r = x / y;
      end
      5'd4:  r = x & y;
      5'd5:  r = x | y;
      5'd6:  r = x ^ y;
      5'd7:  r = ~(x | y);
      5'd8:  begin r = ~x; f = (x != y); end
      5'd9:  r = x << (y % 32);
      5'd10: r = x >> (y % 32);
      5'd11: begin f = ($signed(x) < $signed(y)); r = 32'(f); end
      5'd12: begin f = (x < y); r = 32'(f); end
      5'd13: r = x + 1;
      5'd14: r = x - 1;
      5'd15: begin
        lat = 33;
        if (y == 0) begin r = x; e = 1; end
        else r = x % y;
      end
      default: e = 1;
    endcase
  endfunction

  task automatic scramble();
    opcode = 5'($urandom);
    a      = $urandom;
    b      = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [4:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input bit junk);
    logic [31:0] er;
    logic        ef;
    logic        ee;
    int          el;
    int          lat;
    int          bad;
    ref_op(op, x, y, er, ef, ee, el);
    @(negedge clk);
    start = 1; opcode = op; a = x; b = y;
    @(negedge clk);
    start = junk;
    if (junk) scramble();
    lat = 1;
    bad = 0;
    while (!valid && lat <= 40) begin
      if (!busy) bad++;
      @(negedge clk);
      if (junk) scramble();
      lat++;
    end
    start = 0;
    if (!busy) bad++;
    chk({tag, ".lat"}, 64'(lat), 64'(el));
    chk({tag, ".busy"}, 64'(bad), 64'd0);
    chk({tag, ".res"}, 64'(result), 64'(er));
    chk({tag, ".flag"}, 64'(flag), 64'(ef));
    chk({tag, ".err"}, 64'(err), 64'(ee));
    @(negedge clk);
    chk({tag, ".vpulse"}, 64'(valid), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    chk({tag, ".hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    int nv;
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    rst = 1; start = 1; opcode = 0; a = 32'd3; b = 32'd4;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.valid", 64'(valid), 0);
    chk("rst.res", 64'(result), 0);
    chk("rst.flag", 64'(flag), 0);
    chk("rst.err", 64'(err), 0);
    rst = 0; start = 0;

    do_op("add55", 5'd0, 32'd5, 32'd5, 0);
    do_op("slt", 5'd11, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sltu", 5'd12, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("mul", 5'd2, 32'hFFFF_FFFE, 32'd3, 0);
    do_op("divu", 5'd3, 32'd100, 32'd7, 0);
    do_op("remu", 5'd15, 32'd100, 32'd7, 0);
    do_op("divu0", 5'd3, 32'd1234, 32'd0, 0);
    do_op("remu0", 5'd15, 32'd1234, 32'd0, 0);
    do_op("mul.junk", 5'd2, 32'h1234_5678, 32'h9ABC_DEF1, 1);
    do_op("illegal", 5'b10101, 32'd9, 32'd9, 0);
    do_op("sll", 5'd9, 32'd1, 32'h0000_0024, 0);
    do_op("addwrap", 5'd0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("decwrap", 5'd14, 32'd0, 32'd0, 0);

    // Abort a divide with reset ten cycles after accept.
    @(negedge clk);
    start = 1; opcode = 5'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 0;
    nv = 0;
    repeat (9) begin
      if (valid) nv++;
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort.busy", 64'(busy), 0);
    chk("abort.valid", 64'(valid), 0);
    chk("abort.res", 64'(result), 0);
    chk("abort.flag", 64'(flag), 0);
    chk("abort.err", 64'(err), 0);
    repeat (40) begin
      if (valid) nv++;
      @(negedge clk);
    end
    chk("abort.novalid", 64'(nv), 0);
    do_op("abort.add", 5'd0, 32'd7, 32'd8, 0);

    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       op = 5'd2;
          1:       op = 5'd3;
          default: op = 5'd15;
        endcase
      end
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 5) == 0) y = x;
      do_op("rand", op, x, y, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
